// File: rtl/cic3_pkg.sv
// Shared constants, types and helpers for the CIC3 decimator row.
package cic3_pkg;

  localparam int unsigned LOG2R_MAX_DEFAULT = 8;

  // Output width needed to hold the maximum DC gain R^3 = 2^(3*log2r_max).
  function automatic int unsigned out_w(input int unsigned log2r_max);
    return 3 * log2r_max + 1;
  endfunction

  localparam int unsigned OUT_W_DEFAULT = out_w(LOG2R_MAX_DEFAULT);

  typedef logic [OUT_W_DEFAULT-1:0] cic3_word_t;

  // Clamp the requested log2 ratio to the supported range [1, log2r_max].
  function automatic int unsigned clamp_log2r(input int unsigned v,
                                              input int unsigned log2r_max);
    if (v < 1) return 1;
    if (v > log2r_max) return log2r_max;
    return v;
  endfunction

endpackage

// File: rtl/cic3_channel.sv
// One third-order CIC decimator channel: integrators every cycle,
// comb section and output register on the shared strobe.
module cic3_channel
  import cic3_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             ch_en,
  input  logic             strobe,
  input  logic             restart,
  output logic [OUT_W-1:0] out
);

  logic [OUT_W-1:0] i1_q, i2_q, i3_q, d1_q, d2_q, d3_q, out_q;
  logic [OUT_W-1:0] i1_d, i2_d, i3_d, d1_d, d2_d, d3_d, out_d;
  logic [OUT_W-1:0] c1, c2, c3;
  logic             comb_en;

  // Next-state: integrate every cycle, comb on a strobe not overridden by restart.
  always_comb begin
    i1_d    = i1_q + OUT_W'(in_bit);
    i2_d    = i2_q + i1_q;
    i3_d    = i3_q + i2_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    out_d   = out_q;
    comb_en = strobe && !restart;
    c1      = i3_q - d1_q;
    c2      = c1 - d2_q;
    c3      = c2 - d3_q;
    if (comb_en) begin
      d1_d  = i3_q;
      d2_d  = c1;
      d3_d  = c2;
      out_d = c3;
    end
    if (!ch_en) begin
      i1_d  = '0;
      i2_d  = '0;
      i3_d  = '0;
      d1_d  = '0;
      d2_d  = '0;
      d3_d  = '0;
      out_d = '0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q  <= '0;
      i2_q  <= '0;
      i3_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      d3_q  <= '0;
      out_q <= '0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      i3_q  <= i3_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      d3_q  <= d3_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/cic3_filter_row.sv
// Row of NUM_CH CIC3 decimators sharing one decimation-phase controller:
// ratio selection, phase sync, warm-up suppression, valid strobe, sample count.
module cic3_filter_row
  import cic3_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 24,
  parameter  int unsigned LOG2R_MAX = LOG2R_MAX_DEFAULT,
  localparam int unsigned OUT_W     = out_w(LOG2R_MAX),
  localparam int unsigned LR_W      = $clog2(LOG2R_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [LR_W-1:0]         log2r,
  input  logic                    sync,
  output logic [NUM_CH*OUT_W-1:0] out,
  output logic                    out_valid,
  output logic [15:0]             sample_cnt
);

  localparam logic [LOG2R_MAX-1:0] CNT_ONES = '1;

  logic [LOG2R_MAX-1:0] cnt_q, cnt_d, r_last;
  logic [LR_W-1:0]      log2r_q, log2r_d, log2r_eff;
  logic [1:0]           warm_q, warm_d;
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          sample_cnt_q, sample_cnt_d;
  logic                 restart, strobe;

  // Controller next-state: restart wins over a coincident strobe.
  always_comb begin
    log2r_eff    = LR_W'(clamp_log2r(32'(log2r), LOG2R_MAX));
    restart      = sync || (log2r_eff != log2r_q);
    // R-1 as a mask of log2r_q ones; also correct when R = 2^LOG2R_MAX.
    r_last       = ~(CNT_ONES << log2r_q);
    strobe       = (cnt_q == r_last);
    cnt_d        = strobe ? '0 : cnt_q + LOG2R_MAX'(1);
    log2r_d      = log2r_q;
    warm_d       = (strobe && warm_q != 2'd3) ? warm_q + 2'd1 : warm_q;
    out_valid_d  = strobe && (warm_q == 2'd3);
    sample_cnt_d = out_valid_d ? sample_cnt_q + 16'd1 : sample_cnt_q;
    if (restart) begin
      cnt_d        = '0;
      log2r_d      = log2r_eff;
      warm_d       = '0;
      out_valid_d  = 1'b0;
      sample_cnt_d = '0;
    end
  end

  // Controller registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      log2r_q      <= LR_W'(LOG2R_MAX);
      warm_q       <= '0;
      out_valid_q  <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      log2r_q      <= log2r_d;
      warm_q       <= warm_d;
      out_valid_q  <= out_valid_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cic3_channel #(.OUT_W(OUT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .in_bit  (in[k]),
      .ch_en   (ch_en[k]),
      .strobe  (strobe),
      .restart (restart),
      .out     (out[k*OUT_W +: OUT_W])
    );
  end

  assign out_valid  = out_valid_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: doc/cic3_filter_row.md
# cic3_filter_row

Parametrised row of NUM_CH third-order CIC decimators for 1-bit sigma-delta modulator streams. It replaces the fixed 24-channel, divided-clock row with a single-clock design driven by a shared decimation-strobe controller. Decimation ratio is runtime-selectable, and the block adds phase sync, warm-up suppression, a valid strobe, per-channel enables and a sample counter. It sits between the modulator array inputs and the output buffers / readout logic.

## Interface
- NUM_CH, 24, number of filter channels.
- LOG2R_MAX, 8, log2 of the maximum decimation ratio.
- OUT_W, 3*LOG2R_MAX+1 (derived, not overridable), per-channel output width.
- clk  input  1  filter clock, same frequency as modulator clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  NUM_CH  modulator bits; in[k] feeds channel k (1 counts as 1, 0 as 0).
- ch_en  input  NUM_CH  per-channel enable.
- log2r  input  $clog2(LOG2R_MAX+1)  requested decimation ratio R = 2^log2r. Quasi-static.
- sync  input  1  one-cycle pulse; realigns the decimation phase.
- out  output  NUM_CH*OUT_W  out[k*OUT_W +: OUT_W] is channel k. Unsigned.
- out_valid  output  1  one-cycle pulse when a new valid sample set is on out.
- sample_cnt  output  16  count of valid samples since reset or sync.

## Operation
- Effective ratio: log2r_eff = log2r clamped to [1, LOG2R_MAX]. It is registered in log2r_q, and R = 2^log2r_q.
- Integrators: three per channel, each OUT_W bits, modulo 2^OUT_W. Every cycle: i1 += in[k]; i2 += i1; i3 += i2.
- Phase counter cnt: LOG2R_MAX bits, counts 0..R-1 and wraps to 0. The strobe is (cnt == R-1).
- Combs (on strobe only):
  - c1 = i3 - d1, c2 = c1 - d2, c3 = c2 - d3, all modulo 2^OUT_W.
  - d1<=i3, d2<=c1, d3<=c2; out[k]<=c3.
- DC gain is R^3. The maximum R^3 = 2^(3*LOG2R_MAX) fits OUT_W. Output is not rescaled for smaller R.
- Warm-up: a 2-bit counter warm, saturating at 3, increments on each strobe.
  - out_valid = registered (strobe && warm==3).
  - out still updates during warm-up.
- Restart event: sync, or log2r_eff != log2r_q. On restart:
  - cnt<=0, warm<=0, sample_cnt<=0, log2r_q<=log2r_eff.
  - Integrators, comb delays and out are not cleared.
- Priority: restart beats strobe in the same cycle; that strobe is discarded (no comb update, no out_valid).
- ch_en[k]=0: all of channel k's integrators, comb delays and out are synchronously cleared and held at 0.
  - Re-enable mid-run gives invalid data on channel k for 3 strobes. Software must discard these; out_valid is common and does not track this.
- sample_cnt increments with each out_valid and wraps 0xFFFF->0.
- Reset values: all integrators, delays, out, cnt, warm, out_valid, sample_cnt = 0; log2r_q = LOG2R_MAX. A differing log2r after reset triggers a restart on the first cycle.

## Timing
- The strobe cycle is cnt==R-1. out is loaded at the rising edge ending that cycle, and out_valid is high for the following cycle only.
- out holds until the next strobe.
- Input-to-output latency: in[k] at cycle t enters i1 at edge t+1. The step response reaches a steady R^3 on the 4th strobe (3 warm-up plus 1).
- After reset with log2r unchanged: the first strobe is at cycle R-1. The first out_valid follows the 4th strobe, i.e. the edge ending cycle 4R-1.
- After a restart at edge e: cnt=0 in cycle e, the next strobe is at cycle e+R-1, and the first out_valid follows the 4th strobe after e.
- Reset asserted mid-sample: all state clears asynchronously. Output and strobe resume only after deassertion, per the rules above.

## Structure
- Package cic3_pkg holds:
  - default LOG2R_MAX;
  - the function out_w(log2r_max) = 3*log2r_max+1;
  - typedef cic3_word_t as logic [OUT_W-1:0];
  - the log2r clamp function.
- Sub-module cic3_channel, instantiated NUM_CH times via generate, contains the integrators, comb delays and out register. Its inputs are in_bit, ch_en, strobe and an effective restart.
- The top holds the shared controller: cnt, log2r_q, warm, out_valid, sample_cnt.
- There is no clock divider and no second clock domain; the strobe is a clock enable.

## Test plan
- Reset, log2r=8, all ch_en=1, in all 1 -> out_valid first pulses after cycle 1023; every channel's out = 16777216 (2^24). sample_cnt = 1, then increments every 256 cycles.
- log2r=3, in alternating 1/0 -> steady out = 256 (R^3/2) on every valid sample; out_valid period 8 cycles.
- log2r=0 and log2r=15 -> clamped to 1 and 8 respectively. Period is 2 and 256 cycles; the value 15 produces no restart after reset.
- sync pulse coincident with a strobe cycle -> no out_valid for that sample. sample_cnt=0. The next out_valid follows exactly 4R cycles after sync.
- ch_en[5]=0 mid-run -> out[5]=0 from the next edge while other channels are unaffected. Re-enable -> out[5] returns to R^3 from the 4th strobe onward.
- Reset asserted between strobes -> out, out_valid and sample_cnt are 0 immediately (asynchronously). Post-deassert behaviour matches the first scenario.
